// File: rtl/alu_wb_buffer_pkg.sv
// Shared types for the ALU writeback buffer: XLEN-dependent widths and the
// entry layout also consumed by the scoreboard writeback mux.
package alu_wb_buffer_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 4;

    typedef logic [XLEN-1:0] xlen_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        xlen_t                    result;
        logic                     branch_res;
    } alu_wb_entry_t;

    function automatic bit depth_ok(input int unsigned d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/alu_wb_buffer_fifo_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the control logic.
module alu_wb_fifo_mem #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_wb_buffer.sv
// In-order FIFO between the ALU result and the scoreboard writeback port.
// Ready depends only on registered occupancy, so there is no input-to-output path.
module alu_wb_buffer
    import alu_wb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     alu_valid_i,
    input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
    input  xlen_t                    alu_result_i,
    input  logic                     alu_branch_res_i,
    output logic                     alu_ready_o,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output xlen_t                    wb_result_o,
    output logic                     wb_branch_res_o,
    input  logic                     wb_ack_i,
    output logic [CNT_W-1:0]         count_o
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $fatal(1, "alu_wb_buffer: DEPTH must be a power of two and at least 2");
    end

    localparam int unsigned EW = $bits(alu_wb_entry_t);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    alu_wb_entry_t    wr_entry, rd_entry;
    logic [EW-1:0]    rd_raw;

    assign alu_ready_o = (count_q != CNT_W'(DEPTH));
    assign wb_valid_o  = (count_q != '0);
    assign push        = alu_valid_i & alu_ready_o & ~flush_i;
    assign pop         = wb_ack_i & wb_valid_o & ~flush_i;

    assign wr_entry = '{trans_id: alu_trans_id_i, result: alu_result_i, branch_res: alu_branch_res_i};

    alu_wb_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) i_mem (
        .clk_i   (clk_i),
        .we_i    (push & ~rst_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_raw)
    );

    // Storage is never cleared, so stale data is hidden whenever the head is empty.
    assign rd_entry        = wb_valid_o ? alu_wb_entry_t'(rd_raw) : '0;
    assign wb_trans_id_o   = rd_entry.trans_id;
    assign wb_result_o     = rd_entry.result;
    assign wb_branch_res_o = rd_entry.branch_res;
    assign count_o         = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Protocol monitors: offered-while-full and ack-while-empty are both dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(alu_valid_i && !alu_ready_o))
                else $warning("alu_wb_buffer: alu_valid_i while buffer full, entry not captured");
            assert (!(wb_ack_i && !wb_valid_o))
                else $warning("alu_wb_buffer: wb_ack_i while buffer empty, ignored");
        end
    end

endmodule
